// File: rtl/seq_controller.sv
// seq_controller -- VeriRisc instruction sequencer.
//
// Runs an 8-phase fetch/execute cycle per instruction. The control outputs
// are a combinational decode of the registered phase plus the current
// opcode and zero flag, so controls follow the phase with no extra latency.
// HLT freezes the sequencer in OP_ADDR until rst.
//
// Optional feature (macro SEQ_CONTROLLER_RETIRE_CNT_EN): adds the `retired`
// output, a wrapping count of instructions completed (edges leaving STORE).
module seq_controller #(
    parameter int OP_WIDTH     = 3,
    parameter int RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_WIDTH-1:0]     opcode,
    input  logic                    zero,
    output logic                    sel,
    output logic                    rd,
    output logic                    ld_ir,
    output logic                    inc_pc,
    output logic                    ld_pc,
    output logic                    halt,
    output logic                    ld_ac,
    output logic                    wr,
    output logic                    data_e,
`ifdef SEQ_CONTROLLER_RETIRE_CNT_EN
    output logic [RETIRE_WIDTH-1:0] retired,
`endif
    output logic [2:0]              phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t     phase_r;
    phase_t     phase_s;
    logic       halted_r;
    logic       halted_s;
    logic [2:0] op_s;
    logic       is_hlt_s;
    logic       is_skz_s;
    logic       is_sto_s;
    logic       is_jmp_s;
    logic       is_aluop_s;

    // Only the three low opcode bits take part in the decode.
    assign op_s       = opcode[2:0];
    assign is_hlt_s   = (op_s == OP_HLT);
    assign is_skz_s   = (op_s == OP_SKZ);
    assign is_sto_s   = (op_s == OP_STO);
    assign is_jmp_s   = (op_s == OP_JMP);
    assign is_aluop_s = (op_s == OP_ADD) || (op_s == OP_AND) ||
                        (op_s == OP_XOR) || (op_s == OP_LDA);

    assign phase = phase_r;

    // Phase and halt state register; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r  <= INST_ADDR;
            halted_r <= 1'b0;
        end else begin
            phase_r  <= phase_s;
            halted_r <= halted_s;
        end
    end

    // Next phase: step mod 8, or freeze in OP_ADDR once HLT is seen there.
    always_comb begin
        phase_s  = phase_r;
        halted_s = halted_r;
        if (halted_r) begin
            phase_s  = phase_r;
            halted_s = 1'b1;
        end else if ((phase_r == OP_ADDR) && is_hlt_s) begin
            phase_s  = phase_r;
            halted_s = 1'b1;
        end else begin
            phase_s  = phase_t'(phase_r + 3'd1);
            halted_s = 1'b0;
        end
    end

    // Control decode; a halted sequencer drives only halt.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        halt   = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted_r) begin
            halt = 1'b1;
        end else begin
            case (phase_r)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt_s;
                end
                OP_FETCH: begin
                    rd = is_aluop_s;
                end
                ALU_OP: begin
                    rd     = is_aluop_s;
                    inc_pc = is_skz_s & zero;
                    ld_pc  = is_jmp_s;
                    data_e = is_sto_s;
                end
                STORE: begin
                    rd     = is_aluop_s;
                    ld_ac  = is_aluop_s;
                    ld_pc  = is_jmp_s;
                    wr     = is_sto_s;
                    data_e = is_sto_s;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_CONTROLLER_RETIRE_CNT_EN
    logic [RETIRE_WIDTH-1:0] retired_r;

    assign retired = retired_r;

    // Count instructions retired: each non-halted edge leaving STORE.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_r <= {RETIRE_WIDTH{1'b0}};
        end else if (!halted_r && (phase_r == STORE)) begin
            retired_r <= retired_r + {{(RETIRE_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end
`endif

endmodule

// File: tb/tb_seq_controller.sv
// Directed self-checking bench for seq_controller. Inputs change and outputs
// are sampled around the falling clock edge. Expected control words are
// hand-written constants in the order
// {sel, rd, ld_ir, inc_pc, ld_pc, halt, ld_ac, wr, data_e}.
module tb_seq_controller;

`ifdef SEQ_CONTROLLER_RETIRE_CNT_EN
    localparam int RW = 2;
`else
    localparam int RW = 16;
`endif

    logic          clk;
    logic          rst;
    logic [2:0]    opcode;
    logic          zero;
    logic          sel, rd, ld_ir, inc_pc, ld_pc, halt, ld_ac, wr, data_e;
    logic [2:0]    phase;
`ifdef SEQ_CONTROLLER_RETIRE_CNT_EN
    logic [RW-1:0] retired;
`endif
    logic [8:0]    ctl_s;

    int vectors;
    int miscompares;

    seq_controller #(.OP_WIDTH(3), .RETIRE_WIDTH(RW)) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .zero    (zero),
        .sel     (sel),
        .rd      (rd),
        .ld_ir   (ld_ir),
        .inc_pc  (inc_pc),
        .ld_pc   (ld_pc),
        .halt    (halt),
        .ld_ac   (ld_ac),
        .wr      (wr),
        .data_e  (data_e),
`ifdef SEQ_CONTROLLER_RETIRE_CNT_EN
        .retired (retired),
`endif
        .phase   (phase)
    );

    assign ctl_s = {sel, rd, ld_ir, inc_pc, ld_pc, halt, ld_ac, wr, data_e};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [8:0] C_NONE  = 9'b000000000;
    localparam logic [8:0] C_P0    = 9'b100000000;
    localparam logic [8:0] C_P1    = 9'b110000000;
    localparam logic [8:0] C_P23   = 9'b111000000;
    localparam logic [8:0] C_P4    = 9'b000100000;
    localparam logic [8:0] C_P4HLT = 9'b000101000;
    localparam logic [8:0] C_RD    = 9'b010000000;
    localparam logic [8:0] C_RDAC  = 9'b010000100;
    localparam logic [8:0] C_INC   = 9'b000100000;
    localparam logic [8:0] C_LDPC  = 9'b000010000;
    localparam logic [8:0] C_DE    = 9'b000000001;
    localparam logic [8:0] C_WRDE  = 9'b000000011;
    localparam logic [8:0] C_HALT  = 9'b000001000;

    task automatic chk(input string tag, input logic [2:0] exp_ph, input logic [8:0] exp_ctl);
        #1;
        vectors++;
        assert ({phase, ctl_s} === {exp_ph, exp_ctl})
        else begin
            miscompares++;
            $error("FAIL %s: observed phase=%0d ctl=%b, expected phase=%0d ctl=%b",
                   tag, phase, ctl_s, exp_ph, exp_ctl);
        end
    endtask

`ifdef SEQ_CONTROLLER_RETIRE_CNT_EN
    task automatic chk_ret(input string tag, input logic [RW-1:0] exp_r);
        vectors++;
        assert (retired === exp_r)
        else begin
            miscompares++;
            $error("FAIL %s: observed retired=%0d, expected retired=%0d", tag, retired, exp_r);
        end
    endtask
`endif

    // Walk n phases of one instruction from phase 0. A full instruction
    // (n == 8) ends back at phase 0; a partial one stops inside phase n-1.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input int n, input logic [8:0] e4, input logic [8:0] e5,
                             input logic [8:0] e6, input logic [8:0] e7);
        logic [8:0] exp_tab [8];
        exp_tab[0] = C_P0;
        exp_tab[1] = C_P1;
        exp_tab[2] = C_P23;
        exp_tab[3] = C_P23;
        exp_tab[4] = e4;
        exp_tab[5] = e5;
        exp_tab[6] = e6;
        exp_tab[7] = e7;
        opcode = op;
        zero   = z;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_ph%0d", tag, i), 3'(i), exp_tab[i]);
            if (!((i == n - 1) && (n < 8))) @(negedge clk);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset", 3'd0, C_P0);

        run_instr("add",      3'd2, 1'b0, 8, C_P4, C_RD,   C_RD,   C_RDAC);
        run_instr("skz_z1",   3'd1, 1'b1, 8, C_P4, C_NONE, C_INC,  C_NONE);
        run_instr("skz_z0",   3'd1, 1'b0, 8, C_P4, C_NONE, C_NONE, C_NONE);
        run_instr("jmp",      3'd7, 1'b1, 8, C_P4, C_NONE, C_LDPC, C_LDPC);
        run_instr("sto",      3'd6, 1'b0, 8, C_P4, C_NONE, C_DE,   C_WRDE);
        run_instr("and_z1",   3'd3, 1'b1, 8, C_P4, C_RD,   C_RD,   C_RDAC);
        run_instr("xor",      3'd4, 1'b0, 8, C_P4, C_RD,   C_RD,   C_RDAC);
        run_instr("lda",      3'd5, 1'b1, 8, C_P4, C_RD,   C_RD,   C_RDAC);
        chk("wrap_to_0", 3'd0, C_P0);

        // Reset in the middle of a JMP, while ld_pc is active.
        run_instr("jmp_rst", 3'd7, 1'b0, 7, C_P4, C_NONE, C_LDPC, C_LDPC);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_jmp", 3'd0, C_P0);

        // HLT: one OP_ADDR cycle with inc_pc and halt, then frozen.
        run_instr("hlt", 3'd0, 1'b0, 5, C_P4HLT, C_NONE, C_NONE, C_NONE);
        @(negedge clk);
        for (int k = 0; k < 22; k++) begin
            chk($sformatf("halted_%0d", k), 3'd4, C_HALT);
            opcode = 3'($urandom_range(7, 0));
            zero   = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        chk("halted_end", 3'd4, C_HALT);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_from_halt", 3'd0, C_P0);

`ifdef SEQ_CONTROLLER_RETIRE_CNT_EN
        chk_ret("ret_reset", 2'd0);
        for (int j = 0; j < 5; j++) begin
            run_instr($sformatf("ret_add%0d", j), 3'd2, 1'b0, 8, C_P4, C_RD, C_RD, C_RDAC);
        end
        chk_ret("ret_wrap", 2'd1);
        run_instr("ret_hlt", 3'd0, 1'b0, 5, C_P4HLT, C_NONE, C_NONE, C_NONE);
        for (int k = 0; k < 10; k++) @(negedge clk);
        chk("ret_halted", 3'd4, C_HALT);
        chk_ret("ret_after_hlt", 2'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
